// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - two-requester round-robin arbiter in front of a single-port RAM; optional grant lock under ARB_LOCK_EN
module ram_port_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  req0_valid,
   input  logic                  req0_we,
   input  logic [ADDR_WIDTH-1:0] req0_addr,
   input  logic [DATA_WIDTH-1:0] req0_wdata,
   input  logic                  req0_lock,
   output logic                  req0_ready,
   output logic                  rsp0_valid,
   output logic [DATA_WIDTH-1:0] rsp0_rdata,
   input  logic                  req1_valid,
   input  logic                  req1_we,
   input  logic [ADDR_WIDTH-1:0] req1_addr,
   input  logic [DATA_WIDTH-1:0] req1_wdata,
   input  logic                  req1_lock,
   output logic                  req1_ready,
   output logic                  rsp1_valid,
   output logic [DATA_WIDTH-1:0] rsp1_rdata,
   output logic                  ram_en,
   output logic                  ram_wr_rdn,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_data_wr,
   input  logic [DATA_WIDTH-1:0] ram_data_rd
);

   logic                  last_gnt;
   logic                  rd_pend;
   logic                  rd_tag;
   logic                  gnt0;
   logic                  gnt1;
   logic                  xfer;
   logic                  sel_we;
   logic                  sel_lock;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0] sel_wdata;

`ifdef ARB_LOCK_EN
   logic [1:0]            lock_own;
`else
   logic                  unused_lock;
   assign unused_lock = req0_lock ^ req1_lock ^ sel_lock;
`endif

   // Grant decision: lock owner has exclusive access, otherwise round-robin on contention; nothing granted in reset
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (rstn) begin
`ifdef ARB_LOCK_EN
         if (lock_own[0]) begin
            gnt0 = req0_valid;
         end else if (lock_own[1]) begin
            gnt1 = req1_valid;
         end else if (req0_valid && req1_valid) begin
            gnt0 = last_gnt;
            gnt1 = !last_gnt;
         end else begin
            gnt0 = req0_valid;
            gnt1 = req1_valid;
         end
`else
         if (req0_valid && req1_valid) begin
            gnt0 = last_gnt;
            gnt1 = !last_gnt;
         end else begin
            gnt0 = req0_valid;
            gnt1 = req1_valid;
         end
`endif
      end
   end

   // Command mux: forward the granted requester's command, all zero when idle
   always_comb begin
      sel_we    = 1'b0;
      sel_lock  = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      if (gnt0) begin
         sel_we    = req0_we;
         sel_lock  = req0_lock;
         sel_addr  = req0_addr;
         sel_wdata = req0_wdata;
      end else if (gnt1) begin
         sel_we    = req1_we;
         sel_lock  = req1_lock;
         sel_addr  = req1_addr;
         sel_wdata = req1_wdata;
      end
   end

   assign req0_ready  = gnt0;
   assign req1_ready  = gnt1;
   assign xfer        = gnt0 | gnt1;
   assign ram_en      = xfer;
   assign ram_wr_rdn  = sel_we;
   assign ram_addr    = sel_addr;
   assign ram_data_wr = sel_wdata;

   assign rsp0_valid  = rd_pend && !rd_tag;
   assign rsp1_valid  = rd_pend && rd_tag;
   assign rsp0_rdata  = rsp0_valid ? ram_data_rd : '0;
   assign rsp1_rdata  = rsp1_valid ? ram_data_rd : '0;

   // Arbitration history and read-return tag; the tag lines up with the RAM's one-cycle read data
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         last_gnt <= 1'b1;
         rd_pend  <= 1'b0;
         rd_tag   <= 1'b0;
      end else begin
         if (xfer) begin
            last_gnt <= gnt1;
         end
         rd_pend <= xfer && !sel_we;
         if (xfer && !sel_we) begin
            rd_tag <= gnt1;
         end
      end
   end

`ifdef ARB_LOCK_EN
   // Lock ownership: a locked beat claims the port, an unlocked beat by the owner releases it
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         lock_own <= 2'b00;
      end else if (xfer) begin
         lock_own <= sel_lock ? {gnt1, gnt0} : 2'b00;
      end
   end
`endif

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Two-requester round-robin arbiter that shares one single-port synchronous RAM (1-cycle registered read, en/wr_rdn control) between two masters.
- Each requester gets a valid/ready command channel and a read-response channel.
- The arbiter issues at most one RAM access per cycle and tags every read so that returned data is steered to the requester that issued it.
- Sits directly in front of the RAM; the RAM port is owned exclusively by this block.

Parameters:
- DATA_WIDTH, 32, RAM word width.
- ADDR_WIDTH, 10, RAM address width (1024 words).

Ports:
- clk  input  1  system clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- req0_valid  input  1  requester 0 command valid.
- req0_we  input  1  1 = write, 0 = read.
- req0_addr  input  ADDR_WIDTH  command address.
- req0_wdata  input  DATA_WIDTH  write data.
- req0_lock  input  1  hold grant after this beat (used only under ARB_LOCK_EN).
- req0_ready  output  1  command accepted this cycle.
- rsp0_valid  output  1  read data valid for requester 0.
- rsp0_rdata  output  DATA_WIDTH  read data.
- req1_* / rsp1_*  same as requester 0.
- ram_en  output  1  RAM enable.
- ram_wr_rdn  output  1  RAM write(1)/read(0).
- ram_addr  output  ADDR_WIDTH  RAM address.
- ram_data_wr  output  DATA_WIDTH  RAM write data.
- ram_data_rd  input  DATA_WIDTH  RAM registered read data.

Behaviour:
- Clock and reset: one clock (clk); rstn is asynchronous, active-low.
- Registered state:
  - last_gnt (1 bit), reset 1, so requester 0 wins the first contention.
  - rd_pend (1 bit), reset 0.
  - rd_tag (1 bit), reset 0.
  - lock_own (2 bits, ARB_LOCK_EN only), reset 00.
- Grant (combinational from the valids and registered state):
  - Only one valid: that requester is granted.
  - Both valid: grant the requester != last_gnt.
  - Neither valid: no grant.
- Ready: reqN_ready = gntN. The command transfers in the cycle where valid && ready. Ready never depends on anything except the valids and registered state, so there is no combinational loop.
- RAM drive:
  - ram_en = any grant.
  - ram_wr_rdn, ram_addr, ram_data_wr are taken from the granted requester.
  - With no grant: ram_en=0 and the other RAM outputs are 0.
- last_gnt updates to the granted index on every transfer and holds otherwise.
- Read return:
  - A read accepted at edge N sets rd_pend=1 and rd_tag=index at edge N. This aligns with ram_data_rd being valid after edge N.
  - rspX_valid = rd_pend && (rd_tag==X), driven from registers.
  - rspX_rdata = ram_data_rd, gated to 0 when rspX_valid=0.
  - Read latency is exactly 1 cycle after acceptance. Back-to-back reads produce back-to-back responses; there is no response backpressure.
  - rd_pend clears on the next edge unless another read is accepted.
- Writes produce no response; the write commits at the accepting edge.
- Throughput: 1 access/cycle. Under continuous contention, grants alternate 0,1,0,1.
- Reset mid-operation:
  - All state returns to reset values immediately (async).
  - Any pending response is dropped (rsp*_valid=0).
  - All ready and ram_en outputs go to 0 while rstn=0.
- Simultaneous write and read by different requesters in the same cycle are impossible (single grant). A read issued the cycle after a write to the same address returns the new data.

Optional Feature:
ARB_LOCK_EN
- Defined:
  - A transfer with reqN_lock=1 sets lock_own to one-hot N.
  - While lock_own is set, only requester N can be granted; the other requester's ready is forced to 0 even if N is idle.
  - A transfer by N with lock=0 clears lock_own after that beat.
  - Reset clears lock_own.
- Undefined: lock_own is not implemented and req*_lock inputs are ignored; arbitration is pure round-robin.

Test Plan:
- Reset release, req0 write addr 0x005 data 0xA5A5_0001, then read 0x005 → req0_ready=1 each cycle; rsp0_valid=1 exactly 1 cycle after the read, rdata=0xA5A5_0001; rsp1_valid stays 0.
- Both valid continuously, req0 reads 0x010, req1 reads 0x020 (preloaded 0x11, 0x22) → first grant goes to req0; grants alternate 0,1,0,1; rsp0 returns 0x11 and rsp1 returns 0x22 on alternating cycles.
- req1 writes 0x3FF=0xDEAD_BEEF, and in the next cycle req0 reads 0x3FF → rsp0_rdata=0xDEAD_BEEF; the wrap-top address decodes correctly.
- Only req1 valid for 4 cycles → req1_ready=1 all 4 cycles; no stall; last_gnt=1.
- rstn pulsed low the cycle after a read is accepted → rsp*_valid=0 and ram_en=0 during reset; after release, req0 wins first contention.
- ARB_LOCK_EN: req0 issues 3 writes with lock=1,1,0 while req1 is valid → req1_ready=0 for those 3 beats, then req1 is granted on the next cycle.
